// File: rtl/inv_cipher_if.sv
// Bus bundle for the iterative AES inverse cipher: start/abort control, key schedule,
// ciphertext in, plaintext and status out.
interface inv_cipher_if;
   logic           cs;
   logic [3:0]     Nr;
   logic [0:127]   cipher_in;
   logic [0:1919]  w;
   logic [0:127]   Decrypted_Msg;
   logic           flag;
   logic           busy;

   modport master (
      output cs, Nr, cipher_in, w,
      input  Decrypted_Msg, flag, busy
   );

   modport slave (
      input  cs, Nr, cipher_in, w,
      output Decrypted_Msg, flag, busy
   );
endinterface

// File: rtl/inv_cipher.sv
// Iterative AES inverse cipher: one transform per clock, result after 4*Nr edges.
// cs low aborts to idle at any time; a finished result is held while cs stays high.
module inv_cipher (
   input logic        clk,
   input logic        rst_n,
   inv_cipher_if.slave bus
);

   typedef enum logic [2:0] {IDLE, INV_SHIFT, INV_SUB, ADD_KEY, INV_MIX, DONE} state_t;

   localparam logic [0:2047] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   state_t        state, state_nxt;
   logic [0:127]  st, st_nxt;
   logic [0:127]  msg, msg_nxt;
   logic [3:0]    round, round_nxt;
   logic          flag, flag_nxt;
   logic          busy, busy_nxt;
   logic          nr_ok;
   logic [3:0]    key_idx;
   logic [0:127]  round_key;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a constant built from bits {8,4,2,1}; covers 09, 0b, 0d, 0e.
   function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
      logic [7:0] x2, x4, x8;
      x2 = xt(a);
      x4 = xt(x2);
      x8 = xt(x4);
      return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
             (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
   endfunction

   function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
      logic [0:127] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[8*(r + 4*((c + r) % 4)) +: 8] = s[8*(r + 4*c) +: 8];
      return o;
   endfunction

   function automatic logic [0:127] inv_sub_bytes(input logic [0:127] s);
      logic [0:127] o;
      o = '0;
      for (int i = 0; i < 16; i++)
         o[8*i +: 8] = INV_SBOX[{s[8*i +: 8], 3'b000} +: 8];
      return o;
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
              gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
              gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
              gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
   endfunction

   function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
      logic [0:127] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         o[32*c +: 32] = inv_mix_col(s[32*c +: 32]);
      return o;
   endfunction

   assign nr_ok     = (bus.Nr == 4'd10) || (bus.Nr == 4'd12) || (bus.Nr == 4'd14);
   // The start edge uses the last round key; every later key read follows the round counter.
   assign key_idx   = (state == IDLE) ? bus.Nr : round;
   assign round_key = bus.w[{key_idx, 7'd0} +: 128];

   always_comb begin
      state_nxt = state;
      st_nxt    = st;
      round_nxt = round;
      msg_nxt   = msg;
      flag_nxt  = flag;
      busy_nxt  = busy;
      if (!bus.cs) begin
         state_nxt = IDLE;
         round_nxt = 4'd0;
         flag_nxt  = 1'b0;
         busy_nxt  = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (nr_ok) begin
                  st_nxt    = bus.cipher_in ^ round_key;
                  round_nxt = bus.Nr - 4'd1;
                  busy_nxt  = 1'b1;
                  flag_nxt  = 1'b0;
                  state_nxt = INV_SHIFT;
               end
            end
            INV_SHIFT: begin
               st_nxt    = inv_shift_rows(st);
               state_nxt = INV_SUB;
            end
            INV_SUB: begin
               st_nxt    = inv_sub_bytes(st);
               state_nxt = ADD_KEY;
            end
            ADD_KEY: begin
               st_nxt = st ^ round_key;
               if (round != 4'd0) begin
                  state_nxt = INV_MIX;
               end else begin
                  msg_nxt   = st ^ round_key;
                  flag_nxt  = 1'b1;
                  busy_nxt  = 1'b0;
                  state_nxt = DONE;
               end
            end
            INV_MIX: begin
               st_nxt    = inv_mix_columns(st);
               round_nxt = (round != 4'd0) ? round - 4'd1 : 4'd0;
               state_nxt = INV_SHIFT;
            end
            DONE: begin
               state_nxt = DONE;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         st    <= '0;
         msg   <= '0;
         round <= 4'd0;
         flag  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         st    <= st_nxt;
         msg   <= msg_nxt;
         round <= round_nxt;
         flag  <= flag_nxt;
         busy  <= busy_nxt;
      end
   end

   assign bus.Decrypted_Msg = msg;
   assign bus.flag          = flag;
   assign bus.busy          = busy;

endmodule

// File: tb/tb_inv_cipher.sv
// Bench for inv_cipher: FIPS-197 vectors, abort/reset/illegal-Nr sequences and a
// random round trip against a forward AES model built from GF(2^8) arithmetic.
module tb_inv_cipher;

   logic clk = 1'b0;
   logic rst_n;
   inv_cipher_if bus();

   inv_cipher dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   logic [7:0] sbox [256];
   localparam logic [0:127] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

   typedef struct {
      logic [3:0]   nr;
      logic [0:255] key;
      logic [0:127] ct;
      logic [0:127] pt;
      int           lat;
   } vec_t;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic       hi;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = {a[6:0], 1'b0};
         if (hi) a = a ^ 8'h1b;
         b  = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   // S-box from its definition: multiplicative inverse followed by the affine map.
   function automatic logic [7:0] sbox_calc(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
         if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
   endfunction

   function automatic logic [0:1919] key_expand(input logic [0:255] key, input int nr);
      logic [31:0]   wd [60];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [0:1919] o;
      int            nk;
      nk = nr - 6;
      rc = 8'h01;
      o  = '0;
      for (int i = 0; i < nk; i++) wd[i] = key[32*i +: 32];
      for (int i = nk; i < 4*(nr + 1); i++) begin
         t = wd[i-1];
         if (i % nk == 0) begin
            t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            t = sub_word(t);
         end
         wd[i] = wd[i-nk] ^ t;
      end
      for (int i = 0; i < 4*(nr + 1); i++) o[32*i +: 32] = wd[i];
      return o;
   endfunction

   function automatic logic [0:127] encrypt(input logic [0:127] pt, input logic [0:1919] w,
                                            input int nr);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [0:127] o;
      for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ w[8*i +: 8];
      for (int rnd = 1; rnd <= nr; rnd++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r + 4*c] = s[r + 4*((c + r) % 4)];
         s = t;
         if (rnd != nr) begin
            for (int c = 0; c < 4; c++) begin
               t[4*c]   = gmul(s[4*c], 8'h02) ^ gmul(s[4*c+1], 8'h03) ^ s[4*c+2] ^ s[4*c+3];
               t[4*c+1] = s[4*c] ^ gmul(s[4*c+1], 8'h02) ^ gmul(s[4*c+2], 8'h03) ^ s[4*c+3];
               t[4*c+2] = s[4*c] ^ s[4*c+1] ^ gmul(s[4*c+2], 8'h02) ^ gmul(s[4*c+3], 8'h03);
               t[4*c+3] = gmul(s[4*c], 8'h03) ^ s[4*c+1] ^ s[4*c+2] ^ gmul(s[4*c+3], 8'h02);
            end
            s = t;
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[128*rnd + 8*i +: 8];
      end
      for (int i = 0; i < 16; i++) o[8*i +: 8] = s[i];
      return o;
   endfunction

   function automatic logic [0:127] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Called on a falling edge with the DUT idle; leaves it idle with cs low.
   task automatic run_dec(input logic [3:0] nr, input logic [0:127] ct, output int lat,
                          output logic [0:127] res, output bit busy_ok);
      busy_ok = 1'b1;
      lat     = -1;
      bus.cs        = 1'b1;
      bus.Nr        = nr;
      bus.cipher_in = ct;
      for (int n = 1; n <= 80; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.flag) begin
            lat = n;
            if (bus.busy) busy_ok = 1'b0;
            break;
         end
         if (!bus.busy) busy_ok = 1'b0;
      end
      res    = bus.Decrypted_Msg;
      bus.cs = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         vt [3];
      int           lat;
      logic [0:127] res, pt, ct;
      bit           bok, keep;
      logic [3:0]   bad_nr [4];

      rst_n         = 1'b0;
      bus.cs        = 1'b0;
      bus.Nr        = 4'd0;
      bus.cipher_in = '0;
      bus.w         = '0;
      for (int x = 0; x < 256; x++) sbox[x] = sbox_calc(8'(x));

      vt[0] = '{4'd10, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, FIPS_PT, 40};
      vt[1] = '{4'd12, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                128'hdda97ca4864cdfe06eaf70a0ec0d7191, FIPS_PT, 48};
      vt[2] = '{4'd14, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h8ea2b7ca516745bfeafc49904b496089, FIPS_PT, 56};

      #12;
      chk("reset_flag", 128'(bus.flag), 128'(0));
      chk("reset_busy", 128'(bus.busy), 128'(0));
      chk("reset_msg", bus.Decrypted_Msg, 128'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 3; i++) begin
         bus.w = key_expand(vt[i].key, int'(vt[i].nr));
         run_dec(vt[i].nr, vt[i].ct, lat, res, bok);
         chk("fips_latency", 128'(lat), 128'(vt[i].lat));
         chk("fips_plaintext", res, vt[i].pt);
         chk("fips_busy", 128'(bok), 128'(1));
      end

      // Abort an AES-128 run on edge 20; the previous plaintext must survive.
      bus.w         = key_expand(vt[0].key, 10);
      bus.cs        = 1'b1;
      bus.Nr        = 4'd10;
      bus.cipher_in = vt[0].ct;
      keep          = 1'b1;
      for (int n = 1; n <= 19; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.Decrypted_Msg !== FIPS_PT || bus.flag) keep = 1'b0;
      end
      bus.cs = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_flag", 128'(bus.flag), 128'(0));
      chk("abort_busy", 128'(bus.busy), 128'(0));
      chk("abort_msg_held", bus.Decrypted_Msg, FIPS_PT);
      chk("abort_msg_during_run", 128'(keep), 128'(1));

      // Restart; Nr and cipher_in are disturbed after the start edge.
      pt            = rand128();
      ct            = encrypt(pt, bus.w, 10);
      bus.cs        = 1'b1;
      bus.Nr        = 4'd10;
      bus.cipher_in = ct;
      lat           = -1;
      for (int n = 1; n <= 80; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (n == 1) begin
            bus.cipher_in = rand128();
            bus.Nr        = 4'd12;
         end
         if (bus.flag) begin
            lat = n;
            break;
         end
      end
      chk("restart_latency", 128'(lat), 128'(40));
      chk("restart_plaintext", bus.Decrypted_Msg, pt);
      keep = 1'b1;
      for (int n = 0; n < 6; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (!bus.flag || bus.busy || bus.Decrypted_Msg !== pt) keep = 1'b0;
      end
      chk("done_hold", 128'(keep), 128'(1));
      bus.cs = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("cs_drop_flag", 128'(bus.flag), 128'(0));
      chk("cs_drop_msg", bus.Decrypted_Msg, pt);

      // Asynchronous reset in the middle of an AES-256 run, then a start on the first edge.
      bus.w         = key_expand({rand128(), rand128()}, 14);
      pt            = rand128();
      ct            = encrypt(pt, bus.w, 14);
      bus.cs        = 1'b1;
      bus.Nr        = 4'd14;
      bus.cipher_in = ct;
      repeat (25) @(posedge clk);
      @(negedge clk);
      chk("busy_before_reset", 128'(bus.busy), 128'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("midrun_reset_flag", 128'(bus.flag), 128'(0));
      chk("midrun_reset_busy", 128'(bus.busy), 128'(0));
      chk("midrun_reset_msg", bus.Decrypted_Msg, 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      lat   = -1;
      for (int n = 1; n <= 80; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.flag) begin
            lat = n;
            break;
         end
      end
      chk("post_reset_latency", 128'(lat), 128'(56));
      chk("post_reset_plaintext", bus.Decrypted_Msg, pt);
      bus.cs = 1'b0;
      @(posedge clk);
      @(negedge clk);

      bad_nr = '{4'd11, 4'd0, 4'd15, 4'd13};
      for (int k = 0; k < 4; k++) begin
         bus.cs = 1'b1;
         bus.Nr = bad_nr[k];
         keep   = 1'b1;
         repeat (60) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.flag || bus.busy || bus.Decrypted_Msg !== pt) keep = 1'b0;
         end
         chk("illegal_nr_idle", 128'(keep), 128'(1));
         bus.cs = 1'b0;
         @(posedge clk);
         @(negedge clk);
      end

      for (int k = 0; k < 3; k++) begin
         int nr;
         nr = 10 + 2*k;
         for (int b = 0; b < 150; b++) begin
            bus.w = key_expand({rand128(), rand128()}, nr);
            pt    = rand128();
            ct    = encrypt(pt, bus.w, nr);
            run_dec(4'(nr), ct, lat, res, bok);
            chk("roundtrip_plaintext", res, pt);
            chk("roundtrip_latency", 128'(lat), 128'(4*nr));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
